// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, word width and memory-stage types.
package y86_pkg;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned CNT_W   = 4;

    localparam logic [ICODE_W-1:0] HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] RET    = 4'h9;
    localparam logic [ICODE_W-1:0] PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } memState_t;

    typedef struct packed {
        logic [ICODE_W-1:0] icode;
        logic [WORD_W-1:0]  valE;
        logic [WORD_W-1:0]  valA;
        logic [WORD_W-1:0]  valP;
    } memReq_t;

    function automatic logic isMemRead(input logic [ICODE_W-1:0] ic);
        return (ic == MRMOVQ) || (ic == RET) || (ic == POPQ);
    endfunction

    function automatic logic isMemWrite(input logic [ICODE_W-1:0] ic);
        return (ic == RMMOVQ) || (ic == PUSHQ) || (ic == CALL);
    endfunction

    // Stack pops address through valA; everything else through valE.
    function automatic logic addrFromValA(input logic [ICODE_W-1:0] ic);
        return (ic == RET) || (ic == POPQ);
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-addressable data memory with 8-byte little-endian write and registered read.
module data_mem
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem[addr + ADDR_W'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    // Read result is held until the next completed transaction; clr zeroes it for non-reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            for (int i = 0; i < 8; i++) begin
                rdata[8*i +: 8] <= mem[addr + ADDR_W'(i)];
            end
        end else if (clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y86 SEQ memory stage: latches a request, waits LATENCY cycles, then performs
// the data-memory access and reports valM/dmem_error with a one-cycle done pulse.
module memory_stage
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LATENCY   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ICODE_W-1:0] icode,
    input  logic [WORD_W-1:0]  valE,
    input  logic [WORD_W-1:0]  valA,
    input  logic [WORD_W-1:0]  valP,
    output logic               busy,
    output logic               done,
    output logic [WORD_W-1:0]  valM,
    output logic               dmem_error
);

    localparam int unsigned       ADDR_W   = $clog2(MEM_BYTES);
    localparam logic [WORD_W-1:0] MAX_ADDR = WORD_W'(MEM_BYTES - 8);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);

    memState_t         state;
    memState_t         nextState;
    logic              accept;
    logic [CNT_W-1:0]  waitCnt;
    memReq_t           reqIn;
    memReq_t           reqLatched;
    memReq_t           req;
    logic [WORD_W-1:0] memAddr;
    logic [WORD_W-1:0] wrData;
    logic              addrErr;
    logic              memOp;
    logic              enterDone;
    logic              memWe;
    logic              memRe;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    nextState = (LATENCY > 0) ? ST_WAIT : ST_DONE;
                end else begin
                    nextState = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (waitCnt == '0) nextState = ST_DONE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // With zero latency the access happens on the accepting edge, so bypass the latch.
    assign reqIn     = {icode, valE, valA, valP};
    assign req       = accept ? reqIn : reqLatched;
    assign memAddr   = addrFromValA(req.icode) ? req.valA : req.valE;
    assign wrData    = (req.icode == CALL) ? req.valP : req.valA;
    assign addrErr   = memAddr > MAX_ADDR;
    assign memOp     = isMemRead(req.icode) || isMemWrite(req.icode);
    assign enterDone = (nextState == ST_DONE) && !reset;
    assign memWe     = enterDone && isMemWrite(req.icode) && !addrErr;
    assign memRe     = enterDone && isMemRead(req.icode) && !addrErr;

    always_ff @(posedge clock) begin
        if (reset) begin
            reqLatched <= '0;
            waitCnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dmem_error <= 1'b0;
        end else begin
            busy <= (nextState == ST_WAIT);
            done <= (nextState == ST_DONE);
            if (accept) begin
                reqLatched <= reqIn;
                waitCnt    <= CNT_INIT;
            end else if (state == ST_WAIT) begin
                waitCnt <= waitCnt - CNT_W'(1);
            end
            if (enterDone) dmem_error <= memOp && addrErr;
        end
    end

    data_mem #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_data_mem (
        .clock (clock),
        .reset (reset),
        .we    (memWe),
        .re    (memRe),
        .clr   (enterDone),
        .addr  (memAddr[ADDR_W-1:0]),
        .wdata (wrData),
        .rdata (valM)
    );

endmodule
